// File: rtl/aes_round_key_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_key_sequencer_pkg
// Description : Shared types, constants and GF(2^8) helpers for the AES-256
//               round key sequencer and its optional InvMixColumns stage.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_round_key_sequencer_pkg;

    localparam int NB = 4;    // columns per AES state
    localparam int NR = 14;   // AES-256 round count

    typedef logic [127:0]  rk_t;
    typedef logic [1919:0] sched_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rk_seq_state_e;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply; with a constant b this folds to a few XORs.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_key_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_key_sequencer_if
// Description : Schedule-in / round-key-out bundle for the round key
//               sequencer. The slave modport is the sequencer side; the
//               master modport is the producer/consumer environment.
//   w_i, w_v_i, decrypt_i, ready_o       : schedule load handshake
//   rk_o, round_o, last_o, rk_v_o,
//   rk_ready_i                           : round key stream handshake
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_round_key_sequencer_if #(
    parameter int NUM_ROUNDS = 14,
    parameter int RK_W       = 128
);
    localparam int IDX_W = $clog2(NUM_ROUNDS + 1);

    logic [(NUM_ROUNDS+1)*RK_W-1:0] w_i;
    logic                           w_v_i;
    logic                           decrypt_i;
    logic                           ready_o;
    logic [RK_W-1:0]                rk_o;
    logic [IDX_W-1:0]               round_o;
    logic                           rk_v_o;
    logic                           rk_ready_i;
    logic                           last_o;

    modport master (
        output w_i, w_v_i, decrypt_i, rk_ready_i,
        input  ready_o, rk_o, round_o, rk_v_o, last_o
    );

    modport slave (
        input  w_i, w_v_i, decrypt_i, rk_ready_i,
        output ready_o, rk_o, round_o, rk_v_o, last_o
    );
endinterface
`default_nettype wire

// File: rtl/aes_round_key_sequencer_inv_mix_columns.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_mix_columns
// Description : Purely combinational AES InvMixColumns on a 128-bit state
//               (column c occupies bits [127-32c -: 32], row 0 in MSB).
//   i_state : input state / round key
//   o_state : InvMixColumns(i_state)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_mix_columns
    import aes_round_key_sequencer_pkg::*;
(
    input  wire rk_t i_state,
    output rk_t      o_state
);
    for (genvar c = 0; c < NB; c++) begin : g_col
        logic [7:0] w_s0, w_s1, w_s2, w_s3;
        assign w_s0 = i_state[127-32*c    -: 8];
        assign w_s1 = i_state[127-32*c-8  -: 8];
        assign w_s2 = i_state[127-32*c-16 -: 8];
        assign w_s3 = i_state[127-32*c-24 -: 8];

        assign o_state[127-32*c    -: 8] = gf_mul(w_s0, 8'h0e) ^ gf_mul(w_s1, 8'h0b)
                                         ^ gf_mul(w_s2, 8'h0d) ^ gf_mul(w_s3, 8'h09);
        assign o_state[127-32*c-8  -: 8] = gf_mul(w_s0, 8'h09) ^ gf_mul(w_s1, 8'h0e)
                                         ^ gf_mul(w_s2, 8'h0b) ^ gf_mul(w_s3, 8'h0d);
        assign o_state[127-32*c-16 -: 8] = gf_mul(w_s0, 8'h0d) ^ gf_mul(w_s1, 8'h09)
                                         ^ gf_mul(w_s2, 8'h0e) ^ gf_mul(w_s3, 8'h0b);
        assign o_state[127-32*c-24 -: 8] = gf_mul(w_s0, 8'h0b) ^ gf_mul(w_s1, 8'h0d)
                                         ^ gf_mul(w_s2, 8'h09) ^ gf_mul(w_s3, 8'h0e);
    end
endmodule
`default_nettype wire

// File: rtl/aes_round_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_key_sequencer
// Description : Holds one AES-256 expanded key schedule and streams it as
//               NUM_ROUNDS+1 round keys over a valid/ready handshake, in
//               forward (encrypt) or reverse (decrypt) order.
//   clk_i     : clock
//   reset_n_i : asynchronous active-low reset
//   bus       : slave side of aes_round_key_sequencer_if (schedule load and
//               round key stream)
// Build option: AES_RK_EQINV_EN - decrypt keys for rounds 1..NUM_ROUNDS-1
//               are emitted as InvMixColumns(rk) (equivalent inverse cipher).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_key_sequencer
    import aes_round_key_sequencer_pkg::*;
#(
    parameter int NUM_ROUNDS = 14,
    parameter int RK_W       = 128
) (
    input wire logic                  clk_i,
    input wire logic                  reset_n_i,
    aes_round_key_sequencer_if.slave  bus
);
    localparam int IDX_W   = $clog2(NUM_ROUNDS + 1);
    localparam int SCHED_W = (NUM_ROUNDS + 1) * RK_W;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_ROUNDS);

    rk_seq_state_e      r_state;
    logic [SCHED_W-1:0] r_sched;
    logic               r_dec;
    logic [IDX_W-1:0]   r_idx;
    logic [RK_W-1:0]    r_rk;
    logic               r_rk_v;
    logic               r_last;
    logic               r_ready;

    // The output register is always loaded with the key it will show next:
    // straight from the incoming schedule on accept (so the first key is
    // valid one cycle later), otherwise from the held schedule at idx+/-1.
    logic [SCHED_W-1:0] w_sel_sched;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_sel_dec;
    logic               w_sel_last;
    logic [RK_W-1:0]    w_key;
    logic [RK_W-1:0]    w_rk_out;

    always_comb begin
        if (r_state == IDLE) begin
            w_sel_sched = bus.w_i;
            w_sel_dec   = bus.decrypt_i;
            w_sel_idx   = bus.decrypt_i ? c_LAST_IDX : '0;
        end else begin
            w_sel_sched = r_sched;
            w_sel_dec   = r_dec;
            // Wrap at either end is never registered: the last beat exits to IDLE.
            w_sel_idx   = r_dec ? (r_idx - IDX_W'(1)) : (r_idx + IDX_W'(1));
        end
        w_sel_last = w_sel_dec ? (w_sel_idx == '0) : (w_sel_idx == c_LAST_IDX);
    end

    // Round key r lives at the top of the schedule first (w0 in the MSBs).
    always_comb begin
        w_key = '0;
        for (int r = 0; r <= NUM_ROUNDS; r++) begin
            if (w_sel_idx == IDX_W'(r))
                w_key = w_sel_sched[SCHED_W-1-RK_W*r -: RK_W];
        end
    end

`ifdef AES_RK_EQINV_EN
    logic [RK_W-1:0] w_key_imc;

    aes_inv_mix_columns u_inv_mix_columns (
        .i_state (w_key),
        .o_state (w_key_imc)
    );

    // Outer keys (first and last round) stay raw in the equivalent inverse cipher.
    assign w_rk_out = (w_sel_dec && (w_sel_idx != '0) && (w_sel_idx != c_LAST_IDX))
                    ? w_key_imc : w_key;
`else
    assign w_rk_out = w_key;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_sched <= '0;
            r_dec   <= 1'b0;
            r_idx   <= '0;
            r_rk    <= '0;
            r_rk_v  <= 1'b0;
            r_last  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.w_v_i) begin
                        r_sched <= bus.w_i;
                        r_dec   <= bus.decrypt_i;
                        r_idx   <= w_sel_idx;
                        r_rk    <= w_rk_out;
                        r_last  <= w_sel_last;
                        r_rk_v  <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (bus.rk_ready_i) begin
                        if (r_last) begin
                            // rk_o and round_o keep their last value while idle.
                            r_rk_v  <= 1'b0;
                            r_last  <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_idx  <= w_sel_idx;
                            r_rk   <= w_rk_out;
                            r_last <= w_sel_last;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o = r_ready;
    assign bus.rk_o    = r_rk;
    assign bus.round_o = r_idx;
    assign bus.rk_v_o  = r_rk_v;
    assign bus.last_o  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_key_sequencer
// Description : Self-checking bench for aes_round_key_sequencer. A reference
//               AES-256 key expansion builds the schedules; a queue model of
//               expected beats is compared against the DUT every cycle.
//               Honours AES_RK_EQINV_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_key_sequencer;

    typedef struct packed {
        logic [127:0] rk;
        logic [3:0]   round;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    beat_t        mq[$];
    logic [127:0] hold;
    logic [127:0] cap_rk;
    logic [3:0]   cap_round;
    logic [1919:0] s_a;
    logic [1919:0] s_64;

    always #5 clk = ~clk;

    aes_round_key_sequencer_if bus ();

    aes_round_key_sequencer dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse (b^254) + affine map.
    function automatic logic [7:0] tb_sbox(input logic [7:0] b);
        logic [7:0] inv  = 8'h01;
        logic [7:0] base = b;
        logic [7:0] e    = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = tb_gmul(inv, base);
            base = tb_gmul(base, base);
        end
        if (b == 8'h00) inv = 8'h00;
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] tb_subword(input logic [31:0] w);
        return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
    endfunction

    function automatic logic [1919:0] tb_expand(input logic [255:0] key);
        logic [31:0]   w[60];
        logic [31:0]   t;
        logic [7:0]    rcon = 8'h01;
        logic [1919:0] s    = '0;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = tb_subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end else if (i % 8 == 4) begin
                t = tb_subword(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int i = 0; i < 60; i++) s[1919-32*i -: 32] = w[i];
        return s;
    endfunction

    function automatic logic [127:0] tb_imc(input logic [127:0] x);
        logic [7:0] m[4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
                                '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                                '{8'h0d, 8'h09, 8'h0e, 8'h0b},
                                '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
        logic [127:0] y = '0;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ tb_gmul(m[r][k], x[127-32*c-8*k -: 8]);
                y[127-32*c-8*r -: 8] = acc;
            end
        return y;
    endfunction

    // Queue the whole expected stream for one accepted schedule.
    task automatic push_stream(input logic [1919:0] s, input logic dec);
        beat_t b;
        int    idx;
        for (int n = 0; n < 15; n++) begin
            idx     = dec ? 14 - n : n;
            b.rk    = s[1919-128*idx -: 128];
`ifdef AES_RK_EQINV_EN
            if (dec && idx != 0 && idx != 14) b.rk = tb_imc(b.rk);
`endif
            b.round = 4'(idx);
            b.last  = (n == 14);
            mq.push_back(b);
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: advances on the same edges as the DUT ----------------
    initial begin
        hold = '0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                hold = '0;
            end else if (mq.size() != 0) begin
                if (bus.rk_ready_i) begin
                    hold = mq[0].rk;
                    void'(mq.pop_front());
                end
            end else if (bus.w_v_i) begin
                push_stream(bus.w_i, bus.decrypt_i);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && reset_n) begin
                check("rk_v", 128'(bus.rk_v_o), 128'(mq.size() != 0));
                check("ready", 128'(bus.ready_o), 128'(mq.size() == 0));
                if (mq.size() != 0) begin
                    check("rk", bus.rk_o, mq[0].rk);
                    check("round", 128'(bus.round_o), 128'(mq[0].round));
                    check("last", 128'(bus.last_o), 128'(mq[0].last));
                end else begin
                    check("rk_hold", bus.rk_o, hold);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input logic [1919:0] s, input logic dec);
        @(negedge clk);
        bus.w_i = s; bus.decrypt_i = dec; bus.w_v_i = 1'b1;
        @(negedge clk);
        // Scramble the inputs right after accept; the stream must not care.
        bus.w_v_i = 1'b0; bus.w_i = ~s; bus.decrypt_i = ~dec;
    endtask

    // mode 0: always ready; 1: 5-cycle stall at round 3 then random;
    // 2: ignored load pulse mid-stream; 3: async reset at round 7.
    task automatic drain(input int mode, input int budget);
        int n     = 0;
        int stall = 0;
        bit stalled = 1'b0;
        while (mq.size() != 0 && n < budget) begin
            if (bus.rk_v_o && bus.last_o) begin
                cap_rk = bus.rk_o; cap_round = bus.round_o;
            end
            case (mode)
                1: begin
                    if (!stalled && bus.rk_v_o && bus.round_o == 4'd3) begin
                        stalled = 1'b1; stall = 5;
                    end
                    if (stall > 0) begin
                        bus.rk_ready_i = 1'b0; stall--;
                    end else begin
                        bus.rk_ready_i = stalled ? 1'($urandom_range(0, 1)) : 1'b1;
                    end
                end
                2: begin
                    bus.rk_ready_i = 1'b1;
                    if (n == 4) begin
                        bus.w_i = s_64; bus.decrypt_i = 1'b1; bus.w_v_i = 1'b1;
                    end else begin
                        bus.w_v_i = 1'b0;
                    end
                end
                3: begin
                    bus.rk_ready_i = 1'b1;
                    if (bus.rk_v_o && bus.round_o == 4'd7) begin
                        #2 reset_n = 1'b0;
                        #1;
                        check("rst_mid_rk_v", 128'(bus.rk_v_o), 128'(0));
                        check("rst_mid_ready", 128'(bus.ready_o), 128'(1));
                        check("rst_mid_rk", bus.rk_o, 128'h0);
                        check("rst_mid_round", 128'(bus.round_o), 128'(0));
                    end
                end
                default: bus.rk_ready_i = 1'b1;
            endcase
            @(negedge clk);
            n++;
        end
        if (mq.size() != 0) check("drain_timeout", 128'(mq.size()), 128'(0));
        if (!reset_n) reset_n = 1'b1;
        bus.rk_ready_i = 1'b1;
        bus.w_v_i      = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0;
        bus.w_i = '0; bus.w_v_i = 1'b0; bus.decrypt_i = 1'b0; bus.rk_ready_i = 1'b0;
        s_a  = tb_expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        s_64 = {240{8'h64}};

        // Pin the reference expansion to known FIPS-197 values.
        check("model_rk0", s_a[1919 -: 128], 128'h000102030405060708090a0b0c0d0e0f);
        check("model_rk1", s_a[1791 -: 128], 128'h101112131415161718191a1b1c1d1e1f);
        check("model_rk14", s_a[127:0], 128'h24fc79ccbf0979e9371ac23c6d68de36);
`ifdef AES_RK_EQINV_EN
        check("model_imc", tb_imc({4{32'h8e4da1bc}}), {4{32'hdb135345}});
`endif

        // 1. reset with clocks running
        repeat (3) @(negedge clk);
        check("rst_ready", 128'(bus.ready_o), 128'(1));
        check("rst_rk_v", 128'(bus.rk_v_o), 128'(0));
        check("rst_rk", bus.rk_o, 128'h0);
        check("rst_round", 128'(bus.round_o), 128'(0));
        check("rst_last", 128'(bus.last_o), 128'(0));
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // 2. encrypt, consumer always ready
        bus.rk_ready_i = 1'b1;
        load(s_a, 1'b0);
        check("enc_first_rk", bus.rk_o, 128'h000102030405060708090a0b0c0d0e0f);
        check("enc_first_round", 128'(bus.round_o), 128'(0));
        @(negedge clk);
        check("enc_second_rk", bus.rk_o, 128'h101112131415161718191a1b1c1d1e1f);
        drain(0, 200);
        check("enc_last_rk", cap_rk, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        check("enc_last_round", 128'(cap_round), 128'(14));
        check("enc_ready_after", 128'(bus.ready_o), 128'(1));

        // 3. decrypt
        load(s_a, 1'b1);
        check("dec_first_rk", bus.rk_o, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        check("dec_first_round", 128'(bus.round_o), 128'(14));
        drain(0, 200);
        check("dec_last_rk", cap_rk, 128'h000102030405060708090a0b0c0d0e0f);
        check("dec_last_round", 128'(cap_round), 128'(0));

        // 4. backpressure
        load(s_a, 1'b0);
        drain(1, 300);
        check("bp_last_rk", cap_rk, 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // 5a. load attempt mid-stream is ignored
        load(s_a, 1'b0);
        drain(2, 200);
        check("ign_last_rk", cap_rk, 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // 5b. reset mid-stream, then a fresh schedule streams from rk0
        load(s_a, 1'b0);
        drain(3, 200);
        load(s_64, 1'b0);
        check("post_rst_rk", bus.rk_o, {16{8'h64}});
        check("post_rst_round", 128'(bus.round_o), 128'(0));
        drain(0, 200);

        // 6. decrypt then encrypt again (equivalent-inverse keys when enabled)
        load(s_a, 1'b1);
        drain(1, 300);
        check("d6_last_rk", cap_rk, 128'h000102030405060708090a0b0c0d0e0f);
        load(s_a, 1'b0);
        drain(0, 200);
        check("e6_last_rk", cap_rk, 128'h24fc79ccbf0979e9371ac23c6d68de36);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
